lsu_rv32i: RTL and testbench

Load/store unit for the RV32I datapath. It sits between the control unit/ALU and the 256×32 data memory. It accepts one load or store request per handshake, checks it for alignment, range and legal funct3, then drives the memory's write-enable, store-type, address and store-data inputs for exactly one cycle. For loads it extracts and sign/zero-extends the addressed byte, halfword or word from the memory's asynchronous read data and returns it through a ready/valid response port.

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_rv32i_load_align.sv | 38 +++
 rtl/lsu_rv32i.sv | 125 ++++++++++++
 tb/tb_lsu_rv32i.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants and types for the RV32I load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_SW = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SB = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  // Illegal widths land on ST_SW; they always fault, so memory never sees them.
  function automatic logic [1:0] f3_to_storetype(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return ST_SB;
      2'b01:   return ST_SH;
      default: return ST_SW;
    endcase
  endfunction

endpackage

// File: rtl/lsu_rv32i_load_align.sv
// Picks the addressed byte/halfword/word out of a memory word and extends it.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_dmem_out,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_dmem_out[7:0];
    case (i_addr_lo)
      2'b00: w_byte = i_dmem_out[7:0];
      2'b01: w_byte = i_dmem_out[15:8];
      2'b10: w_byte = i_dmem_out[23:16];
      2'b11: w_byte = i_dmem_out[31:24];
      default: w_byte = i_dmem_out[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_dmem_out[31:16] : i_dmem_out[15:0];
  end

  always_comb begin
    o_rdata = '0;
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_rdata = {24'h0, w_byte};
      F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
      F3_HU:   o_rdata = {16'h0, w_half};
      F3_W:    o_rdata = i_dmem_out;
      default: o_rdata = '0;
    endcase
  end

endmodule

// File: rtl/lsu_rv32i.sv
// RV32I load/store unit: request check, one-cycle memory access, held response.
module lsu_rv32i
  import lsu_pkg::*;
#(
  parameter int unsigned DMEM_BYTES = 1024
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        cu_store,
  output logic [1:0]  cu_storetype,
  output logic [31:0] dmem_addr,
  output logic [31:0] rs2,
  input  logic [31:0] dmem_out
);

  state_t      r_state;
  state_t      w_next;
  logic        r_store;
  logic        r_fault;
  logic        r_rsp_fault;
  logic [2:0]  r_funct3;
  logic [1:0]  r_storetype;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        w_accept;
  logic        w_f3_ok;
  logic        w_misalign;
  logic        w_range;
  logic        w_fault;
  logic [31:0] w_load;

  always_comb begin
    w_f3_ok = 1'b0;
    case (req_funct3)
      F3_B, F3_H, F3_W: w_f3_ok = 1'b1;
      F3_BU, F3_HU:     w_f3_ok = !req_store;
      default:          w_f3_ok = 1'b0;
    endcase
    w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    w_range    = req_addr >= 32'(DMEM_BYTES);
    w_fault    = !w_f3_ok || w_misalign || w_range;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // req_ready is gated by reset_n so it reads 0 while reset is held.
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    cu_store  = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = reset_n;
        w_accept  = req_valid && reset_n;
        if (w_accept) w_next = ACCESS;
      end
      ACCESS: begin
        cu_store = r_store && !r_fault;
        w_next   = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_store     <= 1'b0;
      r_fault     <= 1'b0;
      r_funct3    <= '0;
      r_storetype <= ST_SW;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_rsp_fault <= 1'b0;
    end else begin
      if (w_accept) begin
        r_store     <= req_store;
        r_fault     <= w_fault;
        r_funct3    <= req_funct3;
        r_storetype <= f3_to_storetype(req_funct3);
        r_addr      <= req_addr;
        r_wdata     <= req_wdata;
      end
      if (r_state == ACCESS) begin
        r_rdata     <= (!r_store && !r_fault) ? w_load : '0;
        r_rsp_fault <= r_fault;
      end
    end
  end

  load_align u_align (
    .i_dmem_out (dmem_out),
    .i_funct3   (r_funct3),
    .i_addr_lo  (r_addr[1:0]),
    .o_rdata    (w_load)
  );

  assign rsp_rdata    = r_rdata;
  assign rsp_fault    = r_rsp_fault;
  assign dmem_addr    = r_addr;
  assign rs2          = r_wdata;
  assign cu_storetype = r_storetype;

endmodule

// File: tb/tb_lsu_rv32i.sv
// Scoreboard bench for lsu_rv32i with a byte-level memory reference model.
module tb_lsu_rv32i;

  localparam int PER = 10;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        cu_store;
  logic [1:0]  cu_storetype;
  logic [31:0] dmem_addr;
  logic [31:0] rs2;
  logic [31:0] dmem_out;

  always #(PER/2) clock = ~clock;

  lsu_rv32i #(.DMEM_BYTES(1024)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_fault(rsp_fault), .cu_store(cu_store), .cu_storetype(cu_storetype),
    .dmem_addr(dmem_addr), .rs2(rs2), .dmem_out(dmem_out)
  );

  // Data memory: asynchronous read, write on the falling edge.
  logic [31:0] dmem [256];
  assign dmem_out = dmem[dmem_addr[9:2]];
  always @(negedge clock) begin
    if (cu_store) begin
      case (cu_storetype)
        2'b00: dmem[dmem_addr[9:2]] <= rs2;
        2'b01: dmem[dmem_addr[9:2]][16*dmem_addr[1] +: 16] <= rs2[15:0];
        2'b10: dmem[dmem_addr[9:2]][8*dmem_addr[1:0] +: 8] <= rs2[7:0];
        default: ;
      endcase
    end
  end

  // Reference model: flat byte array.
  logic [7:0] ref_mem [1024];

  typedef struct { logic [31:0] rdata; logic fault; } rsp_t;
  typedef struct { logic [31:0] addr; logic [1:0] st; logic [31:0] data; } wr_t;
  rsp_t exp_q[$];
  wr_t  wr_q[$];
  time  acc_q[$];

  int   checks = 0;
  int   errors = 0;
  int   rdy_mode = 1;
  time  last_acc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_fault(input logic st, input logic [2:0] f3, input logic [31:0] a);
    logic legal;
    int unsigned n;
    legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    n = 1 << f3[1:0];
    return !legal || (a % n != 0) || (a >= 1024);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int unsigned n;
    logic [31:0] v;
    n = 1 << f3[1:0];
    v = '0;
    for (int unsigned i = 0; i < n; i++) v = v | (32'(ref_mem[int'(a[9:0]) + int'(i)]) << (8*i));
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
    return v;
  endfunction

  task automatic finish_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    rsp_t e;
    wr_t  w;
    logic f;
    int unsigned n;
    f = model_fault(st, f3, a);
    n = 1 << f3[1:0];
    e.fault = f;
    e.rdata = (st || f) ? 32'h0 : model_load(f3, a);
    if (st && !f) begin
      w.addr = a;
      w.st   = (n == 4) ? 2'b00 : (n == 2) ? 2'b01 : 2'b10;
      w.data = wd;
      wr_q.push_back(w);
      for (int unsigned i = 0; i < n; i++) ref_mem[int'(a[9:0]) + int'(i)] = wd[8*i +: 8];
    end
    exp_q.push_back(e);
    @(negedge clock);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    for (int k = 0; k < 50 && !req_ready; k++) @(negedge clock);
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready stayed 0, required 1");
      finish_run();
    end
    last_acc = $time;
    acc_q.push_back($time);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clock);
      k++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
      finish_run();
    end
  endtask

  initial forever begin
    @(posedge clock);
    #1;
    if (rdy_mode == 0)      rsp_ready = ($urandom_range(0, 3) != 0);
    else if (rdy_mode == 1) rsp_ready = 1'b1;
    else                    rsp_ready = 1'b0;
  end

  // Monitor: store port, response hold, latency and scoreboard compare.
  logic        prev_stall = 1'b0;
  logic        prev_valid = 1'b0;
  logic [31:0] prev_d = '0;
  logic        prev_f = 1'b0;
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (cu_store) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cu_store: got 1 expected 0 (no store pending) at %0t", $time);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("store_addr", dmem_addr, w.addr);
          chk("store_type", 32'(cu_storetype), 32'(w.st));
          chk("store_data", rs2, w.data);
        end
      end
      if (prev_stall) begin
        chk("hold_valid", 32'(rsp_valid), 32'd1);
        chk("hold_rdata", rsp_rdata, prev_d);
        chk("hold_fault", 32'(rsp_fault), 32'(prev_f));
      end
      if (rsp_valid) begin
        chk("req_ready_in_resp", 32'(req_ready), 32'd0);
        if (!prev_valid) begin
          if (acc_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL latency: rsp_valid with no accepted request at %0t", $time);
          end else begin
            time t;
            t = acc_q.pop_front();
            chk("latency", 32'($time - t), 32'(2*PER));
          end
        end
        if (rsp_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rsp_unexpected: response with empty scoreboard at %0t", $time);
          end else begin
            rsp_t e;
            e = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_fault", 32'(rsp_fault), 32'(e.fault));
          end
        end
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_valid = rsp_valid;
      prev_d     = rsp_rdata;
      prev_f     = rsp_fault;
    end
  end

  initial begin
    time t0;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    int          r;

    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
    for (int w = 0; w < 256; w++)
      dmem[w] = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};

    repeat (3) @(negedge clock);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_fault", 32'(rsp_fault), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_cu_store", 32'(cu_store), 32'd0);
    chk("rst_storetype", 32'(cu_storetype), 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_rs2", rs2, 32'd0);
    @(posedge clock); #2;
    reset_n = 1'b1;

    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    issue(1'b0, 3'b000, 32'h11, 32'h0);
    issue(1'b0, 3'b100, 32'h13, 32'h0);
    issue(1'b0, 3'b001, 32'h12, 32'h0);
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    issue(1'b1, 3'b010, 32'h20, 32'h0);
    issue(1'b1, 3'b000, 32'h21, 32'hAA);
    issue(1'b0, 3'b010, 32'h20, 32'h0);
    issue(1'b0, 3'b010, 32'h02, 32'h0);
    issue(1'b1, 3'b001, 32'h05, 32'h1234);
    issue(1'b1, 3'b010, 32'h400, 32'h55AA55AA);
    issue(1'b0, 3'b011, 32'h10, 32'h0);
    issue(1'b1, 3'b100, 32'h14, 32'h77);
    issue(1'b0, 3'b010, 32'h3FC, 32'h0);
    issue(1'b0, 3'b101, 32'h12, 32'h0);
    idle(1);
    drain();

    // Response stall: rsp_ready low for three RESP cycles.
    rdy_mode = 2;
    @(posedge clock); #2;
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    repeat (4) @(posedge clock);
    rdy_mode = 1;
    idle(0);
    @(posedge clock);
    @(posedge clock); #2;
    chk("idle_after_resp_ready", 32'(req_ready), 32'd1);
    chk("idle_after_resp_valid", 32'(rsp_valid), 32'd0);
    drain();

    // Reset pulsed inside ACCESS, before the falling edge.
    @(negedge clock);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h30; req_wdata = 32'h12345678;
    @(posedge clock); #2;
    chk("access_cu_store", 32'(cu_store), 32'd1);
    reset_n = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("reset_cu_store_drop", 32'(cu_store), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    @(negedge clock); #2;
    reset_n = 1'b1;
    issue(1'b0, 3'b010, 32'h30, 32'h0);
    idle(1);
    drain();

    // Back-to-back with req_valid held high.
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    t0 = last_acc;
    for (int i = 1; i < 5; i++) begin
      issue(1'b0, 3'(i % 2), 32'(32'h20 + i), 32'h0);
      chk("b2b_spacing", 32'(last_acc - t0), 32'(3*PER));
      t0 = last_acc;
    end
    idle(1);
    drain();

    rdy_mode = 0;
    for (int n = 0; n < 200; n++) begin
      st = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 9);
      if (r < 8) begin
        if (st) f3 = 3'($urandom_range(0, 2));
        else begin
          case ($urandom_range(0, 4))
            0: f3 = 3'b000;
            1: f3 = 3'b001;
            2: f3 = 3'b010;
            3: f3 = 3'b100;
            default: f3 = 3'b101;
          endcase
        end
      end else f3 = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      if (r < 8)       a = 32'($urandom_range(0, 63));
      else if (r == 8) a = 32'($urandom_range(1016, 1040));
      else             a = $urandom;
      issue(st, f3, a, $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(1);
    rdy_mode = 1;
    drain();
    repeat (3) @(negedge clock);
    chk("final_exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("final_wr_q_empty", 32'(wr_q.size()), 32'd0);
    finish_run();
  end

  initial begin
    #(PER * 20000);
    checks++; errors++;
    $display("FAIL global_timeout: simulation did not complete");
    finish_run();
  end

endmodule
